// File: rtl/scm_fifo_ctrl.sv
// FIFO controller wrapping a latch-based 1R/1W SCM, with a one-entry skid register
// that hides the registered read latency. Optional flush port under SCM_FIFO_FLUSH_EN.
module scm_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef SCM_FIFO_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      scm_we,
    output logic [ADDR_WIDTH-1:0]     scm_waddr,
    output logic [DATA_WIDTH-1:0]     scm_wdata,
    output logic [DATA_WIDTH/8-1:0]   scm_wbe,
    output logic                      scm_re,
    output logic [ADDR_WIDTH-1:0]     scm_raddr,
    input  logic [DATA_WIDTH-1:0]     scm_rdata,
    output logic [ADDR_WIDTH:0]       fill
);

    localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W     = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_vis;
    logic [CNT_W-1:0]      r_fill;
    logic                  r_rd_valid;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_q;

    logic w_flush;
    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;
    logic w_issue;
    logic w_rd_consumed;
    logic w_move;
    logic w_release;

`ifdef SCM_FIFO_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Handshakes and read scheduling; in_ready depends on registered fill only.
    assign w_in_ready    = ~w_flush & (r_fill < CNT_W'(NUM_WORDS));
    assign w_out_valid   = ~w_flush & (r_rd_valid | r_skid_valid);
    assign w_push        = in_valid & w_in_ready;
    assign w_pop         = w_out_valid & out_ready;
    assign w_issue       = ~w_flush & (r_vis != '0)
                         & ~(r_rd_valid & r_skid_valid & ~w_pop);
    assign w_rd_consumed = w_pop & ~r_skid_valid;
    // Word on scm_rdata would be overwritten by the new read: park it in skid.
    assign w_move        = w_issue & r_rd_valid & ~w_rd_consumed;
    assign w_release     = w_rd_consumed | w_move;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_skid_valid ? r_skid_q : scm_rdata;
    assign scm_we    = w_push;
    assign scm_waddr = r_wr_ptr;
    assign scm_wdata = in_data;
    assign scm_wbe   = '1;
    assign scm_re    = w_issue;
    assign scm_raddr = r_rd_ptr;
    assign fill      = r_fill;

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_vis        <= '0;
            r_fill       <= '0;
            r_rd_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_vis  <= r_vis + CNT_W'(w_push) - CNT_W'(w_issue);
            r_fill <= r_fill + CNT_W'(w_push) - CNT_W'(w_release);

            if (w_issue) begin
                r_rd_valid <= 1'b1;
            end else if (w_rd_consumed) begin
                r_rd_valid <= 1'b0;
            end

            if (w_move) begin
                r_skid_valid <= 1'b1;
            end else if (w_pop && r_skid_valid) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    // Skid data carries no reset; its valid flag qualifies it.
    always_ff @(posedge clk) begin
        if (w_move) begin
            r_skid_q <= scm_rdata;
        end
    end

endmodule
